// File: rtl/pio_in_edge_capture.sv
// rtl/pio_in_edge_capture.sv - Avalon-MM parallel input port with per-bit edge capture and masked interrupt
//
// Purpose:
//   Synchronises WIDTH asynchronous inputs into clk, detects rising, falling
//   or any edges per bit, and latches them in a sticky capture register.
//   A level interrupt is raised when any captured bit is also enabled in
//   the interrupt mask.
//
// Parameters:
//   WIDTH       - number of input bits (1..32)
//   EDGE_TYPE   - 0 = rising, 1 = falling, 2 = any edge
//   SYNC_STAGES - synchroniser depth (2..4)
//
// Ports:
//   clk         - system clock
//   reset_n     - asynchronous active-low reset
//   address     - word address: 0 DATA (RO), 1 reserved, 2 IRQ_MASK (RW),
//                 3 EDGE_CAPTURE (write 1 to clear)
//   chipselect  - slave select
//   write_n     - active-low write strobe
//   writedata   - write data
//   in_port     - asynchronous external inputs
//   readdata    - read data, registered, read latency 1
//   irq         - level interrupt, active high, registered

module pio_in_edge_capture #(
  parameter int WIDTH       = 4,
  parameter int EDGE_TYPE   = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam int              CNT_W    = $clog2(SYNC_STAGES + 2);
  localparam logic [CNT_W-1:0] WARM_MAX = CNT_W'(SYNC_STAGES + 1);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] r_sync;
  logic [WIDTH-1:0]                  r_prev;
  logic [CNT_W-1:0]                  r_warm;
  logic [WIDTH-1:0]                  r_mask;
  logic [WIDTH-1:0]                  r_cap;
  logic [31:0]                       r_readdata;
  logic                              r_irq;

  logic [WIDTH-1:0] w_sync_in;
  logic [WIDTH-1:0] w_rise;
  logic [WIDTH-1:0] w_fall;
  logic [WIDTH-1:0] w_det;
  logic             w_warm_done;
  logic             w_wr;
  logic [WIDTH-1:0] w_clr;
  logic [31:0]      w_rd_mux;
  logic             w_unused_wdata;

  // Upper writedata bits are only meaningful when WIDTH is 32.
  assign w_unused_wdata = ^writedata;

  assign w_sync_in = r_sync[SYNC_STAGES-1];

  // Synchroniser chain plus the one-cycle-delayed copy used for edge detect.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync <= '0;
      r_prev <= '0;
    end else begin
      if (SYNC_STAGES > 1) begin
        for (int i = SYNC_STAGES - 1; i > 0; i--) begin
          r_sync[i] <= r_sync[i-1];
        end
      end
      r_sync[0] <= in_port;
      r_prev    <= w_sync_in;
    end
  end

  // Warm-up: edge detection stays off until the chain and r_prev hold real
  // samples, so inputs already high out of reset are not seen as edges.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_warm <= '0;
    end else if (r_warm != WARM_MAX) begin
      r_warm <= r_warm + 1'b1;
    end
  end

  assign w_warm_done = (r_warm == WARM_MAX);

  assign w_rise = w_sync_in & ~r_prev;
  assign w_fall = ~w_sync_in & r_prev;

  always_comb begin
    w_det = '0;
    if (w_warm_done) begin
      case (EDGE_TYPE)
        0:       w_det = w_rise;
        1:       w_det = w_fall;
        default: w_det = w_rise | w_fall;
      endcase
    end
  end

  assign w_wr  = chipselect & ~write_n;
  assign w_clr = (w_wr && address == 2'd3) ? writedata[WIDTH-1:0] : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mask <= '0;
    end else if (w_wr && address == 2'd2) begin
      r_mask <= writedata[WIDTH-1:0];
    end
  end

  // A new edge in the same cycle as its clear wins: set is applied after clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cap <= '0;
    end else begin
      r_cap <= (r_cap & ~w_clr) | w_det;
    end
  end

  always_comb begin
    w_rd_mux = '0;
    case (address)
      2'd0:    w_rd_mux[WIDTH-1:0] = w_sync_in;
      2'd2:    w_rd_mux[WIDTH-1:0] = r_mask;
      2'd3:    w_rd_mux[WIDTH-1:0] = r_cap;
      default: w_rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_readdata <= '0;
      r_irq      <= 1'b0;
    end else begin
      r_readdata <= w_rd_mux;
      r_irq      <= |(r_cap & r_mask);
    end
  end

  assign readdata = r_readdata;
  assign irq      = r_irq;

endmodule

// File: tb/tb_pio_in_edge_capture.sv
// tb/tb_pio_in_edge_capture.sv - directed self-checking bench for pio_in_edge_capture

module tb_pio_in_edge_capture;

  logic        clk;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [3:0]  in_port;
  logic [31:0] rd0;
  logic [31:0] rd2;
  logic        irq0;
  logic        irq2;

  int n_assert;
  int n_fail;

  // Rising-edge instance.
  pio_in_edge_capture #(.WIDTH(4), .EDGE_TYPE(0), .SYNC_STAGES(2)) u_dut0 (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .in_port    (in_port),
    .readdata   (rd0),
    .irq        (irq0)
  );

  // Any-edge instance on the same bus and inputs.
  pio_in_edge_capture #(.WIDTH(4), .EDGE_TYPE(2), .SYNC_STAGES(2)) u_dut2 (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .in_port    (in_port),
    .readdata   (rd2),
    .irq        (irq2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic bus_read(input logic [1:0] a);
    address    = a;
    chipselect = 1'b1;
    write_n    = 1'b1;
    tick(1);
    chipselect = 1'b0;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick(1);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  initial begin
    n_assert   = 0;
    n_fail     = 0;
    reset_n    = 1'b0;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'h0;
    in_port    = 4'b1010;

    // In reset
    tick(2);
    check("reset_readdata", rd0, 32'h0);
    check("reset_irq", {31'h0, irq0}, 32'h0);

    // 1: reset release with inputs already high
    reset_n = 1'b1;
    tick(10);
    bus_read(2'd3);
    check("t1_cap_type0", rd0, 32'h0);
    check("t1_cap_type2", rd2, 32'h0);
    check("t1_irq0", {31'h0, irq0}, 32'h0);
    check("t1_irq2", {31'h0, irq2}, 32'h0);
    bus_read(2'd0);
    check("t1_data", rd0, 32'h0000000A);
    bus_read(2'd1);
    check("t1_reserved", rd0, 32'h0);

    // 2: rising edge on bit 2, exact latency
    bus_write(2'd2, 32'hF);
    address = 2'd3;
    in_port = 4'b1110;
    tick(3);
    check("t2_cap_not_yet", rd0, 32'h0);
    check("t2_irq_not_yet", {31'h0, irq0}, 32'h0);
    tick(1);
    check("t2_cap_set", rd0, 32'h4);
    check("t2_irq_set", {31'h0, irq0}, 32'h1);
    in_port = 4'b1010;
    tick(6);
    bus_read(2'd3);
    check("t2_fall_ignored", rd0, 32'h4);

    // 3: W1C partial then full clear
    in_port = 4'b1011;
    tick(6);
    bus_read(2'd3);
    check("t3_cap5", rd0, 32'h5);
    bus_write(2'd3, 32'h4);
    bus_read(2'd3);
    check("t3_cap1", rd0, 32'h1);
    check("t3_irq_stays", {31'h0, irq0}, 32'h1);
    bus_write(2'd3, 32'h1);
    check("t3_irq_lag", {31'h0, irq0}, 32'h1);
    tick(1);
    check("t3_irq_clear", {31'h0, irq0}, 32'h0);
    bus_read(2'd3);
    check("t3_cap0", rd0, 32'h0);

    // 4: edge and clear in the same cycle, edge wins
    in_port = 4'b1010;
    tick(6);
    bus_write(2'd3, 32'hF);
    in_port = 4'b1011;
    tick(2);
    bus_write(2'd3, 32'h1);
    bus_read(2'd3);
    check("t4_edge_wins", rd0, 32'h1);
    bus_write(2'd3, 32'h1);
    bus_read(2'd3);
    check("t4_cleared", rd0, 32'h0);

    // 5: masked capture, then unmask
    bus_write(2'd2, 32'h0);
    in_port = 4'b0011;
    tick(6);
    bus_write(2'd3, 32'hF);
    in_port = 4'b1011;
    tick(6);
    bus_read(2'd3);
    check("t5_cap8", rd0, 32'h8);
    check("t5_irq_masked", {31'h0, irq0}, 32'h0);
    bus_write(2'd2, 32'h8);
    check("t5_irq_lag", {31'h0, irq0}, 32'h0);
    tick(1);
    check("t5_irq_unmasked", {31'h0, irq0}, 32'h1);
    bus_read(2'd2);
    check("t5_mask_read", rd0, 32'h00000008);

    // 6: any-edge instance, sticky toggles, then reset mid-sequence
    bus_write(2'd3, 32'hF);
    bus_write(2'd2, 32'hF);
    in_port = 4'b1001;
    tick(2);
    in_port = 4'b1011;
    tick(6);
    bus_read(2'd3);
    check("t6_sticky_type2", rd2, 32'h2);
    check("t6_rise_type0", rd0, 32'h2);
    bus_write(2'd3, 32'hF);
    bus_read(2'd3);
    check("t6_clear_type2", rd2, 32'h0);
    in_port = 4'b1001;
    tick(6);
    bus_read(2'd3);
    check("t6_single_type2", rd2, 32'h2);
    check("t6_fall_type0", rd0, 32'h0);
    check("t6_irq2", {31'h0, irq2}, 32'h1);
    reset_n = 1'b0;
    #1;
    check("t6_rst_readdata", rd2, 32'h0);
    check("t6_rst_irq", {31'h0, irq2}, 32'h0);
    @(negedge clk);
    in_port = 4'b1011;
    tick(2);
    reset_n = 1'b1;
    tick(10);
    bus_read(2'd3);
    check("t6_post_cap_type2", rd2, 32'h0);
    check("t6_post_cap_type0", rd0, 32'h0);
    bus_read(2'd2);
    check("t6_post_mask", rd2, 32'h0);
    bus_read(2'd0);
    check("t6_post_data", rd2, 32'h0000000B);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
